// File: rtl/sample_framer.sv
// sample_framer: pulls samples from the ADC FIFO and emits SYNC/seq/flags/payload/checksum
// byte frames on a ready/valid stream, reporting FIFO errors in the flags byte.
module sample_framer #(
    parameter int         WIDTH   = 16,
    parameter int         SAMPLES = 32,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_ready,
    input  logic             fifo_error,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready
);
    localparam int         B         = (WIDTH + 7) / 8;
    localparam int         SW        = B * 8;
    localparam logic [7:0] B_LAST    = 8'(B - 1);
    localparam logic [8:0] N_SAMPLES = 9'(SAMPLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_FLAGS,
        ST_FETCH,
        ST_DATA,
        ST_CSUM
    } state_t;

    state_t        state;
    logic [7:0]    seq;
    logic [7:0]    csum;
    logic [7:0]    bidx;
    logic [8:0]    sent;
    logic [1:0]    gap;
    logic          err_pending;
    logic [SW-1:0] sample;
    logic          load_ok;
    logic          flag;

    assign load_ok = !byte_valid || byte_ready;
    assign flag    = err_pending | fifo_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            fifo_ready  <= 1'b0;
            seq         <= 8'h00;
            csum        <= 8'h00;
            bidx        <= 8'h00;
            sent        <= 9'd0;
            gap         <= 2'd2;
            err_pending <= 1'b0;
            sample      <= '0;
        end else begin
            if (byte_valid && byte_ready)
                byte_valid <= 1'b0;
            if (fifo_error)
                err_pending <= 1'b1;
            // idle cycles since the last pull, saturating so a pull is allowed after reset
            gap <= fifo_ready ? 2'd0 : (gap == 2'd2 ? gap : gap + 2'd1);
            case (state)
                ST_IDLE: if (enable) state <= ST_SYNC;
                ST_SYNC: if (load_ok) begin
                    byte_out   <= SYNC;
                    byte_valid <= 1'b1;
                    csum       <= 8'h00;
                    sent       <= 9'd0;
                    state      <= ST_SEQ;
                end
                ST_SEQ: if (load_ok) begin
                    byte_out   <= seq;
                    byte_valid <= 1'b1;
                    csum       <= csum ^ seq;
                    state      <= ST_FLAGS;
                end
                ST_FLAGS: if (load_ok) begin
                    byte_out    <= {7'b0, flag};
                    byte_valid  <= 1'b1;
                    csum        <= csum ^ {7'b0, flag};
                    err_pending <= 1'b0;
                    state       <= ST_FETCH;
                end
                ST_FETCH: if (fifo_ready) begin
                    fifo_ready <= 1'b0;
                    sample     <= SW'(fifo_data);
                    sent       <= sent + 9'd1;
                    bidx       <= 8'h00;
                    state      <= ST_DATA;
                end else if (gap >= 2'd2) begin
                    fifo_ready <= 1'b1;
                end
                ST_DATA: if (load_ok) begin
                    byte_out   <= sample[7:0];
                    byte_valid <= 1'b1;
                    csum       <= csum ^ sample[7:0];
                    sample     <= sample >> 8;
                    bidx       <= bidx + 8'd1;
                    if (bidx == B_LAST)
                        state <= sent < N_SAMPLES ? ST_FETCH : ST_CSUM;
                end
                ST_CSUM: if (load_ok) begin
                    byte_out   <= csum;
                    byte_valid <= 1'b1;
                    seq        <= seq + 8'd1;
                    state      <= enable ? ST_SYNC : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
